// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_pkg
//  Purpose  : Default sizing constants and the pointer-wrap helper for sync_fifo.
//  Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    localparam int c_default_buffer_size = 127;
    localparam int c_default_data_width  = 32;

    // Pointers wrap at size-1 so depths that are not a power of two work.
    function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int size);
        return (ptr == 32'(size - 1)) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_ram
//  Purpose  : DEPTH x WIDTH storage, synchronous write port, asynchronous read port.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_ram #(
    parameter int DEPTH  = 127,
    parameter int WIDTH  = 32,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]  i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [WIDTH-1:0]  o_rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = mem[i_rd_addr];

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock show-ahead FIFO with full back-pressure and ack pop.
//  Revision : 1.0  initial release
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int BUFFER_SIZE = c_default_buffer_size,
    parameter int DATA_WIDTH  = c_default_data_width
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_full,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ack
);

    localparam int c_ptr_w = $clog2(BUFFER_SIZE);
    localparam int c_cnt_w = $clog2(BUFFER_SIZE + 1);

    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]    count_q, count_d;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rd_data;

    // Flags come straight from the registered count, so reset clears them at once.
    assign data_in_full   = (count_q == c_cnt_w'(BUFFER_SIZE));
    assign data_out_valid = (count_q != '0);
    assign data_out       = data_out_valid ? w_rd_data : '0;

    assign w_push = data_in_valid & ~data_in_full;
    assign w_pop  = data_out_ack & data_out_valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = c_ptr_w'(ptr_next(32'(wr_ptr_q), BUFFER_SIZE));
        end
        if (w_pop) begin
            rd_ptr_d = c_ptr_w'(ptr_next(32'(rd_ptr_q), BUFFER_SIZE));
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    fifo_ram #(
        .DEPTH  (BUFFER_SIZE),
        .WIDTH  (DATA_WIDTH),
        .ADDR_W (c_ptr_w)
    ) u_ram (
        .clk       (clock),
        .i_wr_en   (w_push),
        .i_wr_addr (wr_ptr_q),
        .i_wr_data (data_in),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sync_fifo
//  Purpose  : Directed scoreboard bench for sync_fifo (127 x 32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo;

    localparam int c_depth = 127;
    localparam int c_width = 32;

    logic               clock = 1'b0;
    logic               rst;
    logic [c_width-1:0] data_in;
    logic               data_in_valid;
    logic               data_in_full;
    logic [c_width-1:0] data_out;
    logic               data_out_valid;
    logic               data_out_ack;

    int                 n_checks = 0;
    int                 n_errors = 0;
    logic [c_width-1:0] sb_q [$];

    always #5 clock = ~clock;

    sync_fifo #(
        .BUFFER_SIZE (c_depth),
        .DATA_WIDTH  (c_width)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .data_in_full   (data_in_full),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ack   (data_out_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Outputs against the scoreboard: valid, full and head word.
    task automatic check_outputs(input string tag);
        check({tag, ".valid"}, 32'(data_out_valid), 32'(sb_q.size() != 0));
        check({tag, ".full"},  32'(data_in_full),   32'(sb_q.size() == c_depth));
        check({tag, ".data"},  data_out, (sb_q.size() != 0) ? sb_q[0] : 32'd0);
    endtask

    // One clock of stimulus; the bench decides acceptance from its own occupancy.
    task automatic step(input string tag, input logic v, input logic [31:0] d, input logic a);
        logic               push_ok;
        logic               pop_ok;
        logic [c_width-1:0] dropped;
        @(negedge clock);
        data_in_valid = v;
        data_in       = d;
        data_out_ack  = a;
        push_ok = v && (sb_q.size() < c_depth);
        pop_ok  = a && (sb_q.size() > 0);
        @(posedge clock);
        #1;
        if (pop_ok) dropped = sb_q.pop_front();
        if (push_ok) sb_q.push_back(d);
        check_outputs(tag);
    endtask

    task automatic drain(input string tag);
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 400) begin
            step(tag, 1'b0, 32'd0, 1'b1);
            guard++;
        end
        check({tag, ".drained"}, 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] wdata;

        // 1. reset, then idle
        rst           = 1'b1;
        data_in       = '0;
        data_in_valid = 1'b0;
        data_out_ack  = 1'b0;
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clock);
        #1;
        check_outputs("reset_held");
        @(negedge clock);
        rst = 1'b0;
        repeat (3) step("idle", 1'b0, 32'd0, 1'b0);

        // 2. walking-one pushes, then pop them in order
        for (int i = 0; i < 8; i++) step("walk_push", 1'b1, 32'd1 << i, 1'b0);
        for (int i = 0; i < 8; i++) step("walk_pop", 1'b0, 32'd0, 1'b1);
        check("walk_empty", 32'(data_out_valid), 32'd0);

        // 3. fill to full, dropped push, drain
        for (int i = 0; i < c_depth; i++) step("fill", 1'b1, 32'(i), 1'b0);
        check("fill_full", 32'(data_in_full), 32'd1);
        step("fill_drop", 1'b1, 32'h0000_DEAD, 1'b0);
        drain("fill_drain");

        // 4. continuous push/pop with one resident word across the wrap
        wdata = 32'h1000_0000;
        step("wrap_prime", 1'b1, wdata, 1'b0);
        for (int i = 0; i < 300; i++) begin
            wdata = wdata + 32'd1;
            step("wrap", 1'b1, wdata, 1'b1);
        end
        drain("wrap_drain");

        // 5a. push & ack with count=5
        for (int i = 0; i < 5; i++) step("mid_fill", 1'b1, 32'h50 + 32'(i), 1'b0);
        step("mid_both", 1'b1, 32'h55, 1'b1);
        check("mid_count", 32'(dut.count_q), 32'd5);
        drain("mid_drain");

        // 5b. push & ack while full
        for (int i = 0; i < c_depth; i++) step("full_fill", 1'b1, 32'h2000 + 32'(i), 1'b0);
        step("full_both", 1'b1, 32'h0000_BEEF, 1'b1);
        check("full_count", 32'(dut.count_q), 32'(c_depth - 1));
        drain("full_drain");

        // 5c. push & ack while empty
        step("empty_both", 1'b1, 32'h0000_0E0E, 1'b1);
        check("empty_count", 32'(dut.count_q), 32'd1);
        drain("empty_drain");

        // 6. asynchronous reset mid-stream
        for (int i = 0; i < 10; i++) step("rst_fill", 1'b1, 32'h300 + 32'(i), 1'b0);
        @(negedge clock);
        data_in_valid = 1'b0;
        #2;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_outputs("async_rst");
        @(negedge clock);
        rst = 1'b0;
        step("post_rst_push", 1'b1, 32'h0000_00A5, 1'b0);
        check("post_rst_data", data_out, 32'h0000_00A5);
        drain("post_rst_drain");

        step("final_idle", 1'b0, 32'd0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
